// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// No logic here: overlap mode encoding, default widths and the length clamp helper.
package seq_det_pkg;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 5;
  localparam int DEF_CNT_W = 8;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with a runtime ceiling; clr+inc in one cycle yields 1.
// One-cycle update latency, no backpressure (inc simply holds at i_max).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_q < i_max)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap mode and saturating match count.
// detect is registered (1 clock after the final bit); input is valid-qualified, no backpressure.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic             i_cfg_overlap,
  input  logic             i_in_valid,
  input  logic             i_inbit,
  input  logic             i_count_clr,
  output logic             o_detect,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_busy_fill
);

  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  ovl_mode_e        r_ovl;
  // The oldest history bit is shifted out before it can reach the comparator, so it is not kept.
  logic [PAT_W-2:0] r_hist;
  logic             r_detect;

  logic [LEN_W-1:0] w_fill;
  logic [PAT_W-1:0] w_shift;
  logic [PAT_W-1:0] w_mask;
  logic             w_take;
  logic             w_match;
  logic             w_restart;

  assign w_take  = i_in_valid & ~i_cfg_load;
  assign w_shift = {r_hist, i_inbit};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_match = w_take && (r_len != '0)
                && ((w_shift & w_mask) == (r_pat & w_mask))
                && (w_fill >= (r_len - LEN_W'(1)));

  // Non-overlapping mode demands len fresh bits after every match.
  assign w_restart = w_match && (r_ovl == OVL_OFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat <= '0;
      r_len <= '0;
      r_ovl <= OVL_OFF;
    end else if (i_cfg_load) begin
      r_pat <= i_cfg_pattern;
      r_len <= LEN_W'(clamp_len(int'(i_cfg_len), PAT_W));
      r_ovl <= ovl_mode_e'(i_cfg_overlap);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist   <= '0;
      r_detect <= 1'b0;
    end else begin
      r_detect <= w_match;
      if (i_cfg_load) begin
        r_hist <= '0;
      end else if (w_take) begin
        r_hist <= w_shift[PAT_W-2:0];
      end
    end
  end

  sat_counter #(.W(LEN_W)) u_fill (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cfg_load | w_restart),
    .i_inc   (w_take & ~w_restart),
    .i_max   (r_len),
    .o_q     (w_fill)
  );

  sat_counter #(.W(CNT_W)) u_count (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_count_clr),
    .i_inc   (w_match),
    .i_max   ({CNT_W{1'b1}}),
    .o_q     (o_match_count)
  );

  assign o_detect    = r_detect;
  assign o_busy_fill = (r_len == '0) || (w_fill < r_len);

endmodule
